hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the five-stage core. Each cycle it decides whether the pipeline advances, holds, bubbles or flushes. It drives the `stallCtrl`, `freeze` (pipeline-register enable), PC-enable and IF/ID flush controls consumed by fetch and decode. It also tracks multi-cycle memory waits, a pending branch flush across a freeze, and program halt, and keeps a stall-cycle counter and a memory watchdog.

## Interface
Parameters:
- MAX_WAIT, 255: maximum consecutive `mem_busy` cycles before a watchdog error; range 1..255.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- rs_IFID  in  3  first source register of the instruction in IF/ID (instr[10:8])
- rt_IFID  in  3  second source register of the instruction in IF/ID (instr[7:5])
- usesRs_IFID  in  1  instruction in IF/ID reads rs
- usesRt_IFID  in  1  instruction in IF/ID reads rt
- WrR_IDEX  in  3  destination register in ID/EX
- MemRead_IDEX  in  1  instruction in ID/EX is a load
- RegWrite_IDEX  in  1  instruction in ID/EX writes a register
- takeBranch_EXMEM  in  1  redirect resolved in EX/MEM
- mem_busy  in  1  instruction or data memory is not ready this cycle
- halt_MEMWB  in  1  halt instruction has reached MEM/WB
- freeze  out  1  pipeline-register enable; 1 = all stage registers load
- pc_en  out  1  PC register load enable
- ifid_en  out  1  IF/ID register load enable, ANDed with `freeze` downstream
- stallCtrl  out  1  insert bubble into ID/EX (zeroes RegWrite, MemWrite, MemRead, Branch)
- flush_IFID  out  1  squash IF/ID and ID/EX contents
- halted  out  1  core halted (registered, sticky)
- err  out  1  watchdog timeout (registered, sticky)
- stall_cnt  out  16  saturating count of non-advancing cycles

## Operation
- States: RUN, MEMWAIT, HALTED. Reset enters RUN.
- `load_use` = MemRead_IDEX & RegWrite_IDEX & ((usesRs_IFID & WrR_IDEX==rs_IFID) | (usesRt_IFID & WrR_IDEX==rt_IFID)).
- Priority in each cycle, highest first: rst, HALTED, mem_busy, flush (takeBranch_EXMEM or pend_flush), load_use.
- RUN, mem_busy=1:
  - freeze=0, pc_en=0, ifid_en=0, stallCtrl=0, flush_IFID=0.
  - Next state MEMWAIT.
  - If takeBranch_EXMEM=1, set pend_flush.
- RUN, no mem_busy, flush:
  - freeze=1, pc_en=1, flush_IFID=1, stallCtrl=1, ifid_en=1.
  - Clear pend_flush. load_use is ignored in this cycle.
- RUN, load_use only:
  - freeze=1, pc_en=0, ifid_en=0, stallCtrl=1.
  - The next cycle sees the bubble in ID/EX, so the stall lasts exactly one cycle.
- RUN, none of the above: freeze=1, pc_en=1, ifid_en=1, stallCtrl=0, flush_IFID=0.
- RUN, halt_MEMWB=1 & freeze=1: next state HALTED.
- MEMWAIT:
  - Outputs as in the RUN mem_busy case.
  - takeBranch_EXMEM=1 in any MEMWAIT cycle sets pend_flush.
  - mem_busy=0 → combinational outputs evaluated exactly as in RUN for that cycle; next state RUN.
- HALTED: freeze=0, pc_en=0, ifid_en=0, stallCtrl=0, flush_IFID=0, halted=1. Only rst exits.
- wait_cnt (8-bit):
  - Increments each cycle mem_busy=1; clears when mem_busy=0.
  - When wait_cnt reaches MAX_WAIT while mem_busy=1, err sets and stays set until rst. The pipeline stays frozen.
- stall_cnt increments when pc_en=0 and state≠HALTED. It saturates at 16'hFFFF.

## Timing
- While rst=1, and at the first edge after: state RUN; pend_flush=0, halted=0, err=0, stall_cnt=0, wait_cnt=0.
- While rst=1, outputs are forced to freeze=0, pc_en=0, ifid_en=0, stallCtrl=0, flush_IFID=0.
- freeze, pc_en, ifid_en, stallCtrl and flush_IFID are combinational from state and inputs, with zero-cycle latency.
- halted, err and stall_cnt are registered; each updates one edge after its cause.
- Load-use costs exactly one bubble cycle. A taken branch costs one flush cycle.
- A branch seen during MEMWAIT is honoured on the first cycle with mem_busy=0, even if takeBranch_EXMEM has already deasserted.
- Simultaneous halt_MEMWB and mem_busy: mem_busy wins, and halt is taken on the first unfrozen cycle.
- rst asserted mid-MEMWAIT or in HALTED returns the block to RUN on the next edge, discarding pend_flush.

## Test plan
- Load-use: ID/EX has a load writing R3, and IF/ID reads rt=R3 with usesRt=1 → one cycle of stallCtrl=1, pc_en=0; next cycle pc_en=1; stall_cnt=1.
- Same destination/source match with MemRead_IDEX=0 → no stall; pc_en=1 throughout.
- mem_busy held 4 cycles → freeze=0 for 4 cycles, then freeze=1; stall_cnt=4; state returns to RUN.
- takeBranch_EXMEM pulses in cycle 2 of a 3-cycle mem_busy → flush_IFID=1 in the first cycle after mem_busy drops, then 0.
- MAX_WAIT=5, mem_busy held 10 cycles → err=1 one edge after the 5th busy cycle and stays 1 until rst.
- halt_MEMWB with freeze=1 → halted=1 next edge, freeze=0 thereafter; rst → halted=0, stall_cnt=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard/stall controller: load-use bubbles, branch
// flushes, memory-wait freezes, halt tracking and a memory watchdog.
module hazard_ctrl #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  rs_IFID,
  input  logic [2:0]  rt_IFID,
  input  logic        usesRs_IFID,
  input  logic        usesRt_IFID,
  input  logic [2:0]  WrR_IDEX,
  input  logic        MemRead_IDEX,
  input  logic        RegWrite_IDEX,
  input  logic        takeBranch_EXMEM,
  input  logic        mem_busy,
  input  logic        halt_MEMWB,
  output logic        freeze,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        stallCtrl,
  output logic        flush_IFID,
  output logic        halted,
  output logic        err,
  output logic [15:0] stall_cnt
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] MEMWAIT = 2'd1;
  localparam logic [1:0] HALTED  = 2'd2;

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT - 1);

  logic [1:0] state, state_n;
  logic       pend_flush, pend_n;
  logic [7:0] wait_cnt;
  logic       load_use;
  logic       flush;

  assign load_use = MemRead_IDEX & RegWrite_IDEX &
    ((usesRs_IFID & (WrR_IDEX == rs_IFID)) |
     (usesRt_IFID & (WrR_IDEX == rt_IFID)));

  assign flush  = takeBranch_EXMEM | pend_flush;
  assign halted = (state == HALTED);

  always_comb begin
    freeze     = 1'b0;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    stallCtrl  = 1'b0;
    flush_IFID = 1'b0;
    state_n    = state;
    pend_n     = pend_flush;
    if (rst) begin
      state_n = RUN;
      pend_n  = 1'b0;
    end else if (state == HALTED) begin
      state_n = HALTED;
    end else if (mem_busy) begin
      state_n = MEMWAIT;
      if (takeBranch_EXMEM)
        pend_n = 1'b1;
    end else begin
      freeze  = 1'b1;
      state_n = RUN;
      if (flush) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        stallCtrl  = 1'b1;
        flush_IFID = 1'b1;
        pend_n     = 1'b0;
      end else if (load_use) begin
        stallCtrl = 1'b1;
      end else begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
      end
      if (halt_MEMWB)
        state_n = HALTED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      pend_flush <= 1'b0;
      err        <= 1'b0;
      stall_cnt  <= 16'd0;
      wait_cnt   <= 8'd0;
    end else begin
      state      <= state_n;
      pend_flush <= pend_n;
      if (!mem_busy)
        wait_cnt <= 8'd0;
      else if (wait_cnt != 8'hFF)
        wait_cnt <= wait_cnt + 8'd1;
      // this busy cycle is the MAX_WAIT-th consecutive one
      if (mem_busy && (wait_cnt >= WAIT_LIM))
        err <= 1'b1;
      if (!pc_en && (state != HALTED) && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a combinational vector table plus
// hand-written multi-cycle sequences.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rs_IFID, rt_IFID, WrR_IDEX;
  logic        usesRs_IFID, usesRt_IFID;
  logic        MemRead_IDEX, RegWrite_IDEX;
  logic        takeBranch_EXMEM, mem_busy, halt_MEMWB;
  logic        freeze, pc_en, ifid_en, stallCtrl, flush_IFID;
  logic        halted, err;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.MAX_WAIT(5)) dut (
    .clk(clk),
    .rst(rst),
    .rs_IFID(rs_IFID),
    .rt_IFID(rt_IFID),
    .usesRs_IFID(usesRs_IFID),
    .usesRt_IFID(usesRt_IFID),
    .WrR_IDEX(WrR_IDEX),
    .MemRead_IDEX(MemRead_IDEX),
    .RegWrite_IDEX(RegWrite_IDEX),
    .takeBranch_EXMEM(takeBranch_EXMEM),
    .mem_busy(mem_busy),
    .halt_MEMWB(halt_MEMWB),
    .freeze(freeze),
    .pc_en(pc_en),
    .ifid_en(ifid_en),
    .stallCtrl(stallCtrl),
    .flush_IFID(flush_IFID),
    .halted(halted),
    .err(err),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] rs, rt, wr;
    logic       urs, urt, mr, rw, tb;
    logic [4:0] exp;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {freeze, pc_en, ifid_en, stallCtrl, flush_IFID};
  endfunction

  task automatic idle();
    rs_IFID = 3'd1; rt_IFID = 3'd2; WrR_IDEX = 3'd3;
    usesRs_IFID = 1'b1; usesRt_IFID = 1'b1;
    MemRead_IDEX = 1'b0; RegWrite_IDEX = 1'b1;
    takeBranch_EXMEM = 1'b0; mem_busy = 1'b0; halt_MEMWB = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int nstall;
    rst = 1'b1;
    idle();
    vt[0] = '{3'd1, 3'd2, 3'd3, 1, 1, 1, 1, 0, 5'b11100};
    vt[1] = '{3'd1, 3'd3, 3'd3, 1, 1, 1, 1, 0, 5'b10010};
    vt[2] = '{3'd3, 3'd2, 3'd3, 1, 1, 1, 1, 0, 5'b10010};
    vt[3] = '{3'd1, 3'd3, 3'd3, 1, 0, 1, 1, 0, 5'b11100};
    vt[4] = '{3'd3, 3'd3, 3'd3, 1, 1, 0, 1, 0, 5'b11100};
    vt[5] = '{3'd3, 3'd3, 3'd3, 1, 1, 1, 0, 0, 5'b11100};
    vt[6] = '{3'd3, 3'd3, 3'd3, 1, 1, 1, 1, 1, 5'b11111};
    vt[7] = '{3'd1, 3'd2, 3'd3, 1, 1, 1, 1, 1, 5'b11111};
    vt[8] = '{3'd0, 3'd5, 3'd0, 1, 0, 1, 1, 0, 5'b10010};

    // reset state
    tick();
    #1;
    chk("rst_outs", 16'(outs()), 16'h0);
    tick();
    rst = 1'b0;
    chk("rst_halted", 16'(halted), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    chk("rst_cnt", stall_cnt, 16'h0);

    // combinational table
    do_reset();
    nstall = 0;
    for (int i = 0; i < 9; i++) begin
      rs_IFID = vt[i].rs; rt_IFID = vt[i].rt; WrR_IDEX = vt[i].wr;
      usesRs_IFID = vt[i].urs; usesRt_IFID = vt[i].urt;
      MemRead_IDEX = vt[i].mr; RegWrite_IDEX = vt[i].rw;
      takeBranch_EXMEM = vt[i].tb;
      #1;
      chk($sformatf("vec%0d", i), 16'(outs()), 16'(vt[i].exp));
      if (!vt[i].exp[3]) nstall++;
      tick();
    end
    chk("vec_cnt", stall_cnt, 16'(nstall));

    // load-use then bubble
    do_reset();
    MemRead_IDEX = 1'b1; rt_IFID = 3'd3;
    #1;
    chk("lu_stall", 16'({stallCtrl, pc_en}), 16'b10);
    tick();
    MemRead_IDEX = 1'b0; RegWrite_IDEX = 1'b0;
    #1;
    chk("lu_next", 16'({stallCtrl, pc_en}), 16'b01);
    chk("lu_cnt", stall_cnt, 16'd1);

    // four-cycle memory wait
    do_reset();
    for (int k = 0; k < 4; k++) begin
      mem_busy = 1'b1;
      #1;
      chk($sformatf("mw_frz%0d", k), 16'({freeze, pc_en}), 16'b00);
      tick();
    end
    mem_busy = 1'b0;
    #1;
    chk("mw_run", 16'(outs()), 16'b11100);
    tick();
    chk("mw_cnt", stall_cnt, 16'd4);

    // branch during memory wait is deferred
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      mem_busy = 1'b1;
      takeBranch_EXMEM = (k == 2);
      #1;
      chk($sformatf("bw_fl%0d", k), 16'(flush_IFID), 16'h0);
      tick();
    end
    mem_busy = 1'b0; takeBranch_EXMEM = 1'b0;
    #1;
    chk("bw_flush", 16'(outs()), 16'b11111);
    tick();
    chk("bw_after", 16'(flush_IFID), 16'h0);

    // watchdog
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      mem_busy = 1'b1;
      tick();
      chk($sformatf("wd_err%0d", k), 16'(err), 16'(k >= 5));
    end
    mem_busy = 1'b0;
    tick();
    chk("wd_sticky", 16'(err), 16'h1);
    do_reset();
    chk("wd_clr", 16'(err), 16'h0);

    // halt
    do_reset();
    halt_MEMWB = 1'b1;
    tick();
    halt_MEMWB = 1'b0;
    chk("h_set", 16'(halted), 16'h1);
    #1;
    chk("h_frz", 16'(outs()), 16'h0);
    tick();
    tick();
    chk("h_hold", 16'({halted, freeze}), 16'b10);
    chk("h_cnt", stall_cnt, 16'h0);
    do_reset();
    chk("h_rst", 16'(halted), 16'h0);

    // halt with mem_busy: busy wins first
    do_reset();
    halt_MEMWB = 1'b1; mem_busy = 1'b1;
    #1;
    chk("hb_frz", 16'(freeze), 16'h0);
    tick();
    chk("hb_nohalt", 16'(halted), 16'h0);
    mem_busy = 1'b0;
    tick();
    chk("hb_halt", 16'(halted), 16'h1);

    // reset mid-wait drops the pending flush
    do_reset();
    mem_busy = 1'b1; takeBranch_EXMEM = 1'b1;
    tick();
    do_reset();
    #1;
    chk("rp_noflush", 16'(outs()), 16'b11100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
